colide_scan: RTL and testbench

Parameterised, table-driven collision checker for the movable VGA object. On each start request it latches the object position, size and step. It then walks an obstacle table one entry per clock and reports, for all four movement directions at once, whether moving by `step` would overlap any obstacle or cross the screen edge. It sits between the keyboard/move controller and the position registers, and replaces the per-direction hard-wired checkers with one block of configurable obstacle count and geometry.

---
 rtl/colide_pkg.sv | 29 ++
 rtl/obstacle_rom.sv | 12 +
 rtl/colide_scan.sv | 116 +++++++++++
 tb/tb_colide_scan.sv | 126 ++++++++++++
 4 files changed

// File: rtl/colide_pkg.sv
// colide_pkg: obstacle record type, screen defaults, FSM states and the default maze table.
package colide_pkg;
  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;
  localparam int MAZE_N = 10;
  typedef struct packed {
    logic [15:0] ini_x;
    logic [15:0] fin_x;
    logic [15:0] ini_y;
    logic [15:0] fin_y;
  } obst_t;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  localparam obst_t MAZE [MAZE_N] = '{
    '{16'd100, 16'd350, 16'd100, 16'd105},
    '{16'd340, 16'd350, 16'd100, 16'd275},
    '{16'd100, 16'd280, 16'd170, 16'd175},
    '{16'd270, 16'd280, 16'd170, 16'd345},
    '{16'd400, 16'd410, 16'd200, 16'd470},
    '{16'd450, 16'd600, 16'd50,  16'd55},
    '{16'd100, 16'd105, 16'd250, 16'd470},
    '{16'd150, 16'd400, 16'd420, 16'd425},
    '{16'd500, 16'd505, 16'd100, 16'd400},
    '{16'd200, 16'd450, 16'd300, 16'd305}
  };
  // Indices past the built-in maze read as an all-zero, degenerate record that never hits.
  function automatic obst_t maze_at(input int i);
    return (i < MAZE_N) ? MAZE[$clog2(MAZE_N)'(i)] : '0;
  endfunction
endpackage

// File: rtl/obstacle_rom.sv
// obstacle_rom: combinational lookup of one obstacle record from the package maze table.
module obstacle_rom
  import colide_pkg::*;
#(
  parameter int N_OBST = 10,
  localparam int IW = (N_OBST > 1) ? $clog2(N_OBST) : 1
) (
  input  logic [IW-1:0] i_idx,
  output obst_t         o_rec
);
  assign o_rec = maze_at(int'(i_idx));
endmodule

// File: rtl/colide_scan.sv
// colide_scan: walks the obstacle table one entry per clock and reports, for all four
// directions at once, whether moving by step would hit an obstacle or leave the screen.
module colide_scan
  import colide_pkg::*;
#(
  parameter int N_OBST = 10,
  parameter int X_W = 10,
  parameter int Y_W = 9,
  parameter int SIZE_W = 7,
  parameter int STEP_W = 4,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  localparam int IW = (N_OBST > 1) ? $clog2(N_OBST) : 1
) (
  input  logic              VGA_clk,
  input  logic              reset,
  input  logic              start,
  input  logic [X_W-1:0]    xPos,
  input  logic [Y_W-1:0]    yPos,
  input  logic [SIZE_W-1:0] tamanho,
  input  logic [STEP_W-1:0] step,
  output logic              busy,
  output logic              done,
  output logic              colisao_max_y,
  output logic              colisao_min_y,
  output logic              colisao_max_x,
  output logic              colisao_min_x,
  output logic              hit_valid,
  output logic [IW-1:0]     first_hit
);
  localparam int AW = ((X_W > Y_W) ? X_W : Y_W) + 2;
  localparam logic [AW-1:0] SW = AW'(SCREEN_W);
  localparam logic [AW-1:0] SH = AW'(SCREEN_H);
  localparam logic [IW-1:0] LAST = IW'(N_OBST - 1);
  state_t        r_state;
  logic [IW-1:0] r_idx, r_fh;
  logic [AW-1:0] r_x, r_y, r_t, r_s;
  logic [3:0]    r_acc;
  logic          r_hv;
  obst_t         w_rec;
  logic [AW-1:0] w_ix, w_fx, w_iy, w_fy;
  logic [3:0]    w_hit, w_edge, w_acc;
  logic          w_any;
  obstacle_rom #(.N_OBST(N_OBST)) u_rom (.i_idx(r_idx), .o_rec(w_rec));
  // Half-open interval overlap; an inverted or empty obstacle span never overlaps.
  function automatic logic ov(input logic [AW-1:0] a, t, ini, fin);
    return (ini < fin) && (a + t > ini) && (a < fin);
  endfunction
  assign w_ix = AW'(w_rec.ini_x);
  assign w_fx = AW'(w_rec.fin_x);
  assign w_iy = AW'(w_rec.ini_y);
  assign w_fy = AW'(w_rec.fin_y);
  // Bit order everywhere: {max_y, min_y, max_x, min_x}.
  assign w_hit[3] = ov(r_x, r_t, w_ix, w_fx) && ov(r_y + r_s, r_t, w_iy, w_fy);
  assign w_hit[2] = ov(r_x, r_t, w_ix, w_fx) && ov(r_y - r_s, r_t, w_iy, w_fy);
  assign w_hit[1] = ov(r_x + r_s, r_t, w_ix, w_fx) && ov(r_y, r_t, w_iy, w_fy);
  assign w_hit[0] = ov(r_x - r_s, r_t, w_ix, w_fx) && ov(r_y, r_t, w_iy, w_fy);
  assign w_edge = {r_y + r_s + r_t > SH, r_y < r_s, r_x + r_s + r_t > SW, r_x < r_s};
  assign w_acc = r_acc | w_hit;
  assign w_any = |w_hit;
  always_ff @(posedge VGA_clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx <= '0;
      r_fh <= '0;
      r_hv <= 1'b0;
      r_acc <= '0;
      r_x <= '0;
      r_y <= '0;
      r_t <= '0;
      r_s <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      {colisao_max_y, colisao_min_y, colisao_max_x, colisao_min_x} <= '0;
      hit_valid <= 1'b0;
      first_hit <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_x <= AW'(xPos);
          r_y <= AW'(yPos);
          r_t <= AW'(tamanho);
          r_s <= AW'(step);
          r_acc <= '0;
          r_hv <= 1'b0;
          r_fh <= '0;
          r_idx <= '0;
          busy <= 1'b1;
          r_state <= SCAN;
        end
        SCAN: begin
          r_acc <= w_acc;
          if (w_any && !r_hv) begin
            r_hv <= 1'b1;
            r_fh <= r_idx;
          end
          // Results are registered on the way into DONE so done and the flags appear together.
          if (r_idx == LAST) begin
            {colisao_max_y, colisao_min_y, colisao_max_x, colisao_min_x} <= w_acc | w_edge;
            hit_valid <= r_hv | w_any;
            first_hit <= r_hv ? r_fh : (w_any ? r_idx : '0);
            done <= 1'b1;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: begin
          busy <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_colide_scan.sv
// tb_colide_scan: directed checks of colide_scan timing, flags, edge cases and reset abort.
module tb_colide_scan;
  logic       VGA_clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [9:0] xPos = '0;
  logic [8:0] yPos = '0;
  logic [6:0] tamanho = '0;
  logic [3:0] step = '0;
  logic       busy, done, colisao_max_y, colisao_min_y, colisao_max_x, colisao_min_x, hit_valid;
  logic [3:0] first_hit;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc, nd;
  colide_scan dut (
    .VGA_clk(VGA_clk), .reset(reset), .start(start), .xPos(xPos), .yPos(yPos),
    .tamanho(tamanho), .step(step), .busy(busy), .done(done),
    .colisao_max_y(colisao_max_y), .colisao_min_y(colisao_min_y),
    .colisao_max_x(colisao_max_x), .colisao_min_x(colisao_min_x),
    .hit_valid(hit_valid), .first_hit(first_hit)
  );
  always #5 VGA_clk = ~VGA_clk;
  task automatic tick();
    @(posedge VGA_clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] flags();
    return {23'd0, colisao_max_y, colisao_min_y, colisao_max_x, colisao_min_x, hit_valid, first_hit};
  endfunction
  function automatic logic [31:0] ef(input logic my, miy, mx, mnx, hv, input logic [3:0] fh);
    return {23'd0, my, miy, mx, mnx, hv, fh};
  endfunction
  // Leaves the bench in the cycle done is seen (cycle 11 for a 10-entry table).
  task automatic run(input logic [9:0] x, input logic [8:0] y, input logic [6:0] t,
                     input logic [3:0] s, output int c);
    tick();
    xPos = x; yPos = y; tamanho = t; step = s;
    start = 1'b1;
    tick();
    start = 1'b0;
    c = 1;
    while (!done && c < 40) begin
      tick();
      c++;
    end
  endtask
  initial begin
    start = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    start = 1'b0;
    tick();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_flags", flags(), 32'd0);
    run(10'd200, 9'd90, 7'd10, 4'd1, cyc);
    chk("t1_cycle", cyc, 11);
    chk("t1_flags", flags(), ef(1, 0, 0, 0, 1, 4'd0));
    tick();
    chk("t1_done_pulse", 32'(done), 32'd0);
    chk("t1_hold", flags(), ef(1, 0, 0, 0, 1, 4'd0));
    run(10'd20, 9'd20, 7'd10, 4'd2, cyc);
    chk("t2_cycle", cyc, 11);
    chk("t2_flags", flags(), ef(0, 0, 0, 0, 0, 4'd0));
    run(10'd630, 9'd0, 7'd10, 4'd1, cyc);
    chk("edge_tr_cycle", cyc, 11);
    chk("edge_tr_flags", flags(), ef(0, 1, 1, 0, 0, 4'd0));
    run(10'd1, 9'd0, 7'd10, 4'd2, cyc);
    chk("edge_tl_flags", flags(), ef(0, 1, 0, 1, 0, 4'd0));
    run(10'd329, 9'd150, 7'd10, 4'd2, cyc);
    chk("t4_cycle", cyc, 11);
    chk("t4_flags", flags(), ef(0, 0, 1, 0, 1, 4'd1));
    // Extra starts with different coordinates while busy must not disturb the scan.
    tick();
    xPos = 10'd200; yPos = 9'd90; tamanho = 7'd10; step = 4'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    nd = 0;
    for (int c = 1; c <= 13; c++) begin
      chk($sformatf("ign_busy_c%0d", c), 32'(busy), 32'(c <= 11));
      chk($sformatf("ign_done_c%0d", c), 32'(done), 32'(c == 11));
      nd += int'(done);
      start = (c == 1 || c == 3 || c == 10);
      if (start) begin
        xPos = 10'd20; yPos = 9'd20;
      end
      tick();
    end
    start = 1'b0;
    chk("ign_done_count", nd, 1);
    chk("ign_flags", flags(), ef(1, 0, 0, 0, 1, 4'd0));
    xPos = 10'd329; yPos = 9'd150; tamanho = 7'd10; step = 4'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_flags", flags(), 32'd0);
    nd = 0;
    repeat (20) begin
      tick();
      nd += int'(done);
    end
    chk("abort_no_done", nd, 0);
    chk("abort_idle", 32'(busy), 32'd0);
    run(10'd329, 9'd150, 7'd10, 4'd2, cyc);
    chk("after_abort_cycle", cyc, 11);
    chk("after_abort_flags", flags(), ef(0, 0, 1, 0, 1, 4'd1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
